// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the fetch-side read bus and the UART boot-byte stream
// of the instruction-memory loader.
//   imemraddr  byte address from fetch      imemrdata  registered instruction word
//   rx_data    boot byte                    rx_valid   one-cycle strobe for rx_data
//   loaded     program fully written        load_done  one-cycle pulse as loaded rises
// master: fetch stage + UART side (testbench); slave: the loader.
interface imem_loader_if;
  logic [31:0] imemraddr;
  logic [31:0] imemrdata;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        loaded;
  logic        load_done;

  modport master (
    output imemraddr, rx_data, rx_valid,
    input  imemrdata, loaded, load_done
  );

  modport slave (
    input  imemraddr, rx_data, rx_valid,
    output imemrdata, loaded, load_done
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: instruction memory filled over a UART byte stream at boot.
// Stream format: 4-byte little-endian word count N, then N little-endian words
// written to consecutive word addresses from 0 (wrapping modulo depth).
// Reads return NOP_WORD until the whole program has been written.
//   clk   single clock, rising edge
//   rstn  asynchronous active-low reset (control state only, memory kept)
//   bus   imem_loader_if.slave: fetch read port + boot byte stream + status
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rstn,
  imem_loader_if.slave      bus
);

  localparam int unsigned            Depth  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  PtrOne = 1;

  typedef enum logic [1:0] {StHdr, StData, StDone} state_e;

  state_e                r_state;
  logic [1:0]            r_lane;
  logic [23:0]           r_shift;      // first three bytes of the word in progress
  logic [31:0]           r_wdata;
  logic                  r_wr_pend;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [31:0]           r_count;
  logic                  r_loaded;
  logic                  r_load_done;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [Depth];

  logic [31:0]           w_word;
  logic                  w_last_byte;
  logic [ADDR_WIDTH-1:0] w_ridx;
  logic                  w_unused;

  assign w_word      = {bus.rx_data, r_shift};
  assign w_last_byte = bus.rx_valid && (r_lane == 2'd3);
  assign w_ridx      = bus.imemraddr[ADDR_WIDTH+1:2];
  // Byte offset and address bits above the memory wrap are don't-care.
  assign w_unused    = ^{bus.imemraddr[31:ADDR_WIDTH+2], bus.imemraddr[1:0]};

  // Load FSM. The assembled word is written one cycle after its last byte, and
  // loaded/load_done are raised on that same edge for the final word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StHdr;
      r_lane      <= 2'd0;
      r_shift     <= '0;
      r_wdata     <= '0;
      r_wr_pend   <= 1'b0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_loaded    <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_wr_pend   <= 1'b0;
      if ((r_state != StDone) && bus.rx_valid) begin
        r_lane  <= r_lane + 2'd1;
        r_shift <= {bus.rx_data, r_shift[23:8]};
      end
      unique case (r_state)
        StHdr: begin
          if (w_last_byte) begin
            if (w_word == '0) begin
              r_state     <= StDone;
              r_loaded    <= 1'b1;
              r_load_done <= 1'b1;
            end else begin
              r_state <= StData;
              r_ptr   <= '0;
              r_count <= w_word;
            end
          end
        end
        StData: begin
          if (w_last_byte) begin
            r_wdata   <= w_word;
            r_wr_pend <= 1'b1;
          end
          if (r_wr_pend) begin
            r_ptr   <= r_ptr + PtrOne;
            r_count <= r_count - 32'd1;
            if (r_count == 32'd1) begin
              r_state     <= StDone;
              r_loaded    <= 1'b1;
              r_load_done <= 1'b1;
            end
          end
        end
        StDone: begin
        end
        default: r_state <= StHdr;
      endcase
    end
  end

  // Storage is deliberately not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (r_wr_pend) begin
      r_mem[r_ptr] <= r_wdata;
    end
  end

  // Registered read; old contents on a same-word write (read-first).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
    end else if (!r_loaded) begin
      r_rdata <= NOP_WORD;
    end else begin
      r_rdata <= r_mem[w_ridx];
    end
  end

  assign bus.imemrdata = r_rdata;
  assign bus.loaded    = r_loaded;
  assign bus.load_done = r_load_done;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] Nop = 32'h00000013;

  typedef struct {
    logic        sel;    // 0: default DUT, 1: ADDR_WIDTH=2 DUT
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_bad;
  int   done_a;
  int   done_b;
  vec_t vecs [15];

  imem_loader_if ifa ();
  imem_loader_if ifb ();

  imem_loader u_dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifa.slave)
  );

  imem_loader #(
    .ADDR_WIDTH (2)
  ) u_dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.load_done === 1'b1) done_a++;
    if (ifb.load_done === 1'b1) done_b++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b, input int gap);
    ifa.rx_data  = b;
    ifa.rx_valid = 1'b1;
    @(negedge clk);
    ifa.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] b, input int gap);
    ifb.rx_data  = b;
    ifb.rx_valid = 1'b1;
    @(negedge clk);
    ifb.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic word_a(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_a(w[8*i +: 8], gap);
  endtask

  task automatic word_b(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_b(w[8*i +: 8], 0);
  endtask

  task automatic run_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].sel) ifb.imemraddr = vecs[i].addr;
      else             ifa.imemraddr = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("read_vec%0d", i), vecs[i].sel ? ifb.imemrdata : ifa.imemrdata,
          vecs[i].exp);
    end
  endtask

  task automatic wait_loaded(input logic sel, input string name);
    for (int i = 0; i < 20; i++) begin
      if ((sel ? ifb.loaded : ifa.loaded) === 1'b1) break;
      @(negedge clk);
    end
    chk(name, 32'(sel ? ifb.loaded : ifa.loaded), 32'd1);
  endtask

  // Reset pulse with checks of the reset and first post-reset read values.
  task automatic pulse_reset(input string name);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk({name, "_rdata0"}, ifa.imemrdata, 32'h0);
    chk({name, "_loaded0"}, 32'(ifa.loaded), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk({name, "_nop"}, ifa.imemrdata, Nop);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    done_a = 0;
    done_b = 0;
    vecs[0]  = '{1'b0, 32'h0000_0000, Nop};
    vecs[1]  = '{1'b0, 32'h0000_0004, Nop};
    vecs[2]  = '{1'b0, 32'h0000_1234, Nop};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0513};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0010_0593};
    vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0010_0593};
    vecs[6]  = '{1'b0, 32'h0001_0004, 32'h0010_0593};
    vecs[7]  = '{1'b0, 32'h0000_0003, 32'h0000_0513};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h1122_3344};
    vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0010_0593};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'hB0B0_0004};
    vecs[11] = '{1'b1, 32'h0000_0004, 32'hB0B0_0001};
    vecs[12] = '{1'b1, 32'h0000_0008, 32'hB0B0_0002};
    vecs[13] = '{1'b1, 32'h0000_000C, 32'hB0B0_0003};
    vecs[14] = '{1'b1, 32'h0000_0010, 32'hB0B0_0004};

    ifa.imemraddr = '0;
    ifa.rx_data   = '0;
    ifa.rx_valid  = 1'b0;
    ifb.imemraddr = '0;
    ifb.rx_data   = '0;
    ifb.rx_valid  = 1'b0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst_rdata", ifa.imemrdata, 32'h0);
    chk("rst_loaded", 32'(ifa.loaded), 32'd0);
    chk("rst_load_done", 32'(ifa.load_done), 32'd0);
    @(negedge clk);
    chk("rst_hold_rdata", ifa.imemrdata, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_nop", ifa.imemrdata, Nop);

    run_reads(0, 2);

    // Two-word program, back-to-back bytes.
    word_a(32'd2, 0);
    word_a(32'h0000_0513, 0);
    word_a(32'h0010_0593, 0);
    chk("loaded_not_yet", 32'(ifa.loaded), 32'd0);
    chk("nop_while_loading", ifa.imemrdata, Nop);
    @(negedge clk);
    chk("loaded_rise", 32'(ifa.loaded), 32'd1);
    chk("load_done_pulse", 32'(ifa.load_done), 32'd1);
    @(negedge clk);
    chk("load_done_fall", 32'(ifa.load_done), 32'd0);
    chk("load_done_count", 32'(done_a), 32'd1);

    run_reads(3, 7);

    // Exactly one cycle of read latency.
    ifa.imemraddr = 32'h0;
    @(negedge clk);
    ifa.imemraddr = 32'h4;
    #1;
    chk("lat_hold", ifa.imemrdata, 32'h0000_0513);
    @(negedge clk);
    chk("lat_new", ifa.imemrdata, 32'h0010_0593);

    // Bytes after completion are ignored.
    word_a(32'hFFFF_FFFF, 0);
    word_a(32'hFFFF_FFFF, 0);
    repeat (2) @(negedge clk);
    chk("done_loaded_hold", 32'(ifa.loaded), 32'd1);
    chk("done_no_pulse", 32'(done_a), 32'd1);
    run_reads(3, 5);

    // Reset after 6 data bytes abandons the partial load.
    pulse_reset("rst1");
    word_a(32'd4, 0);
    word_a(32'hCAFE_F00D, 0);
    send_a(8'hEE, 0);
    send_a(8'hEE, 0);
    pulse_reset("rst_mid");
    done_a = 0;

    // Fresh one-word load with idle gaps; mem[1] from the first load survives.
    send_a(8'h01, 50);
    send_a(8'h00, $urandom_range(0, 50));
    send_a(8'h00, $urandom_range(0, 50));
    send_a(8'h00, 0);
    send_a(8'h44, $urandom_range(0, 50));
    send_a(8'h33, 50);
    send_a(8'h22, $urandom_range(0, 50));
    send_a(8'h11, 0);
    wait_loaded(1'b0, "gap_loaded");
    @(negedge clk);
    chk("gap_load_done_count", 32'(done_a), 32'd1);
    run_reads(8, 9);

    // Zero-length program.
    pulse_reset("rst_zero");
    done_a = 0;
    word_a(32'd0, 0);
    chk("zero_loaded", 32'(ifa.loaded), 32'd1);
    chk("zero_load_done", 32'(ifa.load_done), 32'd1);
    @(negedge clk);
    chk("zero_load_done_fall", 32'(ifa.load_done), 32'd0);
    word_a(32'h5555_5555, 0);
    chk("zero_done_count", 32'(done_a), 32'd1);
    run_reads(8, 8);

    // Small memory: five words wrap over a four-word array.
    word_b(32'd5);
    for (int i = 0; i < 5; i++) word_b(32'hB0B0_0000 + 32'(i));
    wait_loaded(1'b1, "wrap_loaded");
    @(negedge clk);
    chk("wrap_done_count", 32'(done_b), 32'd1);
    run_reads(10, 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning word-address width; depth = 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the read data returned while loading.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port imemraddr  input  32  byte address from the fetch stage.
REQ-006 SHALL have port imemrdata  output  32  registered instruction word.
REQ-007 SHALL have port rx_data  input  8  boot byte from the UART receiver.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-009 SHALL have port loaded  output  1  high once the program is fully written; core runs only when high.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse in the cycle loaded rises.

Function
REQ-011 SHALL decode the word index as imemraddr[ADDR_WIDTH+1:2]; bits [1:0] and bits above ADDR_WIDTH+1 ignored (address wrap modulo depth).
REQ-012 SHALL provide read latency of exactly one cycle: imemrdata at edge k+1 = mem[index sampled at edge k].
REQ-013 SHALL drive imemrdata = NOP_WORD at every edge while loaded=0, regardless of imemraddr.
REQ-014 SHALL implement states HDR, DATA, DONE; reset state HDR.
REQ-015 In HDR, SHALL assemble 4 rx_valid bytes little-endian into 32-bit word count N (first byte = bits [7:0]).
REQ-016 On the 4th header byte, SHALL go to DONE if N=0, else to DATA with write pointer 0 and remaining count N.
REQ-017 In DATA, SHALL assemble 4 bytes little-endian per word and write mem[ptr] in the cycle after the 4th byte's edge.
REQ-018 SHALL increment ptr by 1 per written word, wrapping modulo depth; N > depth overwrites earlier words, with no error.
REQ-019 After the Nth word write, SHALL go to DONE; loaded rises in the same edge as the final write and load_done pulses for exactly one cycle.
REQ-020 In DONE, SHALL ignore rx_valid entirely; memory contents and loaded stay fixed until reset.
REQ-021 SHALL ignore cycles with rx_valid=0; no inter-byte timeout; byte-lane counter holds its value.
REQ-022 SHALL use read-first semantics if a read and write target the same word in one cycle (moot while loaded=0, see REQ-013).
REQ-023 SHALL NOT clear memory contents on reset; only control state resets.

Reset
REQ-024 On rstn=0, SHALL asynchronously force state=HDR, byte-lane=0, ptr=0, count=0, loaded=0, load_done=0, imemrdata=0.
REQ-025 After rstn deasserts, SHALL drive imemrdata=NOP_WORD from the first clock edge onward until loaded.
REQ-026 Reset mid-load SHALL abandon the partial word and restart at HDR; the next byte is header byte 0.

Verification
REQ-027 Header 02 00 00 00, bytes 13 05 00 00 93 05 10 00 -> mem[0]=00000513, mem[1]=001005 93, loaded=1, one load_done pulse.
REQ-028 After REQ-027 load, imemraddr=4 at edge k -> imemrdata=00100593 at edge k+1; imemraddr=6 gives same word.
REQ-029 Header 00 00 00 00 -> loaded=1 and load_done pulse in the cycle after 4th byte; further bytes change nothing.
REQ-030 Bytes with gaps of 0-50 idle cycles between rx_valid strobes -> identical memory image to back-to-back delivery.
REQ-031 rstn pulsed low after 6 data bytes -> loaded=0, imemrdata=0 then NOP_WORD; fresh header+data loads correctly.
REQ-032 ADDR_WIDTH=2, N=5 words W0..W4 -> mem[0]=W4, mem[1..3]=W1..W3; address 16 reads mem[0].
